// File: rtl/s_to_p_stream_if.sv
// Valid/ready stream bundle for s_to_p_stream: narrow beats in, packed words out.
// When S_TO_P_LAST_EN is defined the bundle also carries i_last, o_last and o_keep.
interface s_to_p_stream_if #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 4
);
    logic [IWIDTH-1:0]        i_data;
    logic                     i_valid;
    logic                     i_ready;
    logic [IWIDTH*OWIDTH-1:0] o_data;
    logic                     o_valid;
    logic                     o_ready;
`ifdef S_TO_P_LAST_EN
    logic                     i_last;
    logic                     o_last;
    logic [OWIDTH-1:0]        o_keep;
`endif

    // The slave side is the converter; the master side is the surrounding environment.
    modport slave (
        input  i_data, i_valid, o_ready,
`ifdef S_TO_P_LAST_EN
        input  i_last,
        output o_last, o_keep,
`endif
        output i_ready, o_data, o_valid
    );

    modport master (
        output i_data, i_valid, o_ready,
`ifdef S_TO_P_LAST_EN
        output i_last,
        input  o_last, o_keep,
`endif
        input  i_ready, o_data, o_valid
    );
endinterface

// File: rtl/s_to_p_stream.sv
// Double-buffered serial-to-parallel converter: packs OWIDTH IWIDTH-bit beats per output word.
// Optional early word close with lane-keep mask when S_TO_P_LAST_EN is defined.
module s_to_p_stream #(
    parameter int IWIDTH     = 8,
    parameter int OWIDTH     = 4,
    parameter int LANE_ORDER = 0
) (
    input logic           clk,
    input logic           rst,
    s_to_p_stream_if.slave bus
);
    localparam int CW = $clog2(OWIDTH + 1);
    localparam int LW = $clog2(OWIDTH);

    logic [OWIDTH-1:0][IWIDTH-1:0] asm_data;
    logic [OWIDTH-1:0][IWIDTH-1:0] word;
    logic [CW-1:0]                 asm_cnt;
    logic                          asm_full;
    logic [IWIDTH*OWIDTH-1:0]      o_data_r;
    logic                          o_valid_r;
    logic [LW-1:0]                 lane;
    logic                          accept;
    logic                          out_free;
    logic                          early;
    logic                          complete;
    logic                          move_held;
    logic                          move_new;
    logic                          hold_new;

    assign bus.i_ready = !asm_full;
    assign bus.o_data  = o_data_r;
    assign bus.o_valid = o_valid_r;

`ifdef S_TO_P_LAST_EN
    assign early = bus.i_last;
`else
    assign early = 1'b0;
`endif

    assign accept    = bus.i_valid && !asm_full;
    assign out_free  = !o_valid_r || bus.o_ready;
    assign complete  = accept && ((asm_cnt == CW'(OWIDTH - 1)) || early);
    assign move_held = asm_full && out_free;
    assign move_new  = complete && out_free;
    assign hold_new  = complete && !out_free;

    // Assembly word including the beat arriving this cycle, so a completing
    // beat can go straight to the output register without a bubble.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        lane = asm_cnt[LW-1:0];
        if (LANE_ORDER != 0) lane = LW'(OWIDTH - 1) - asm_cnt[LW-1:0];
        word       = asm_data;
        word[lane] = bus.i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: asm_data is reset (and cleared on hand-off) because unwritten lanes must read 0.
            asm_data  <= '0;
            asm_cnt   <= '0;
            asm_full  <= 1'b0;
            o_data_r  <= '0;
            o_valid_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (move_held || move_new) begin
                o_valid_r <= 1'b1;
                o_data_r  <= move_held ? asm_data : word;
            end else if (o_valid_r && bus.o_ready) begin
                o_valid_r <= 1'b0;
            end

            if (move_held || move_new) begin
                asm_data <= '0;
                asm_cnt  <= '0;
                asm_full <= 1'b0;
            end else if (hold_new) begin
                asm_data <= word;
                asm_full <= 1'b1;
            end else if (accept) begin
                asm_data <= word;
                asm_cnt  <= asm_cnt + CW'(1);
            end
        end
    end

`ifdef S_TO_P_LAST_EN
    logic [OWIDTH-1:0] asm_keep;
    logic [OWIDTH-1:0] word_keep;
    logic              asm_last;
    logic [OWIDTH-1:0] o_keep_r;
    logic              o_last_r;

    assign word_keep  = asm_keep | (OWIDTH'(1) << lane);
    assign bus.o_keep = o_keep_r;
    assign bus.o_last = o_last_r;

    // Sideband follows exactly the same move/hold/accept decisions as the data path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_keep <= '0;
            asm_last <= 1'b0;
            o_keep_r <= '0;
            o_last_r <= 1'b0;
        end else begin
            if (move_held) begin
                o_keep_r <= asm_keep;
                o_last_r <= asm_last;
            end else if (move_new) begin
                o_keep_r <= word_keep;
                o_last_r <= early;
            end

            if (move_held || move_new) begin
                asm_keep <= '0;
                asm_last <= 1'b0;
            end else if (hold_new) begin
                asm_keep <= word_keep;
                asm_last <= early;
            end else if (accept) begin
                asm_keep <= word_keep;
            end
        end
    end
`endif
endmodule

// File: tb/tb_s_to_p_stream.sv
// Directed bench for s_to_p_stream: two instances (LANE_ORDER 0 and 1) driven with identical stimulus.
module tb_s_to_p_stream;
    logic       clk;
    logic       rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
`ifdef S_TO_P_LAST_EN
    logic       i_last;
`endif
    int checks = 0;
    int errors = 0;

    s_to_p_stream_if #(.IWIDTH(8), .OWIDTH(4)) bus0 ();
    s_to_p_stream_if #(.IWIDTH(8), .OWIDTH(4)) bus1 ();

    assign bus0.i_data  = i_data;
    assign bus0.i_valid = i_valid;
    assign bus0.o_ready = o_ready;
    assign bus1.i_data  = i_data;
    assign bus1.i_valid = i_valid;
    assign bus1.o_ready = o_ready;
`ifdef S_TO_P_LAST_EN
    assign bus0.i_last  = i_last;
    assign bus1.i_last  = i_last;
`endif

    s_to_p_stream #(.IWIDTH(8), .OWIDTH(4), .LANE_ORDER(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    s_to_p_stream #(.IWIDTH(8), .OWIDTH(4), .LANE_ORDER(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b exp 0", bus0.o_valid); end
        checks++;
        if (bus0.o_data !== 32'h0) begin errors++; $display("FAIL reset_o_data got %h exp 00000000", bus0.o_data); end
        checks++;
        if (bus0.i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready got %b exp 1", bus0.i_ready); end
`ifdef S_TO_P_LAST_EN
        checks++;
        if ({bus0.o_last, bus0.o_keep} !== 5'b0) begin
            errors++; $display("FAIL reset_last_keep got %b%b exp 00000", bus0.o_last, bus0.o_keep);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        o_ready = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            i_valid = 1'b1; i_data = 8'(b);
            @(negedge clk);
            if (b == 3) begin
                checks++;
                if (bus0.o_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", bus0.o_valid); end
            end
        end
        i_valid = 1'b0;
        checks++;
        if (bus0.o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus0.o_valid); end
        checks++;
        if (bus0.o_data !== 32'h04030201) begin errors++; $display("FAIL basic_data_order0 got %h exp 04030201", bus0.o_data); end
        checks++;
        if (bus1.o_data !== 32'h01020304) begin errors++; $display("FAIL basic_data_order1 got %h exp 01020304", bus1.o_data); end
        @(negedge clk);
        checks++;
        if (bus0.o_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", bus0.o_valid); end
    endtask

    task automatic test_backpressure();
        o_ready = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            i_valid = 1'b1; i_data = 8'(b);
            checks++;
            if (bus0.i_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_beat%0d got %b exp 1", b, bus0.i_ready); end
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus0.i_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full c%0d got %b exp 0", c, bus0.i_ready); end
            checks++;
            if (bus0.o_valid !== 1'b1 || bus0.o_data !== 32'h04030201) begin
                errors++; $display("FAIL bp_hold c%0d got %b/%h exp 1/04030201", c, bus0.o_valid, bus0.o_data);
            end
            @(negedge clk);
        end
        checks++;
        if (bus1.o_data !== 32'h01020304) begin errors++; $display("FAIL bp_hold_order1 got %h exp 01020304", bus1.o_data); end
        o_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.o_valid !== 1'b1 || bus0.o_data !== 32'h08070605) begin
            errors++; $display("FAIL bp_second_word got %b/%h exp 1/08070605", bus0.o_valid, bus0.o_data);
        end
        checks++;
        if (bus1.o_data !== 32'h05060708) begin errors++; $display("FAIL bp_second_order1 got %h exp 05060708", bus1.o_data); end
        checks++;
        if (bus0.i_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %b exp 1", bus0.i_ready); end
        @(negedge clk);
        checks++;
        if (bus0.o_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got %b exp 0", bus0.o_valid); end
    endtask

    task automatic test_back_to_back();
        int words = 0;
        logic [31:0] exp_w;
        o_ready = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            logic exp_v;
            exp_v = (i > 0) && (i % 4 == 0);
            checks++;
            if (bus0.o_valid !== exp_v) begin errors++; $display("FAIL b2b_valid i%0d got %b exp %b", i, bus0.o_valid, exp_v); end
            if (exp_v) begin
                int k;
                k = i / 4 - 1;
                exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                checks++;
                if (bus0.o_data !== exp_w) begin errors++; $display("FAIL b2b_word%0d got %h exp %h", k, bus0.o_data, exp_w); end
            end
            if (bus0.o_valid === 1'b1) words++;
            if (i < 64) begin
                i_valid = 1'b1; i_data = 8'(i);
                checks++;
                if (bus0.i_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i%0d got %b exp 1", i, bus0.i_ready); end
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (words != 16) begin errors++; $display("FAIL b2b_word_count got %0d exp 16", words); end
    endtask

    task automatic test_reset_mid_word();
        o_ready = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            i_valid = 1'b1; i_data = 8'(8'h40 + b);
            @(negedge clk);
        end
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus0.o_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", bus0.o_valid); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus0.o_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid c%0d got %b exp 0", c, bus0.o_valid); end
        end
        rst = 1'b0;
        o_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            i_valid = 1'b1; i_data = 8'(8'hAA + 8'h11 * b);
            @(negedge clk);
        end
        i_valid = 1'b0;
        checks++;
        if (bus0.o_valid !== 1'b1 || bus0.o_data !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL rst_next_word got %b/%h exp 1/ddccbbaa", bus0.o_valid, bus0.o_data);
        end
        checks++;
        if (bus1.o_data !== 32'hAABBCCDD) begin errors++; $display("FAIL rst_next_order1 got %h exp aabbccdd", bus1.o_data); end
        @(negedge clk);
    endtask

`ifdef S_TO_P_LAST_EN
    task automatic test_last();
        o_ready = 1'b1;
        i_valid = 1'b1; i_data = 8'h11; i_last = 1'b0;
        @(negedge clk);
        i_data = 8'h22; i_last = 1'b1;
        @(negedge clk);
        i_valid = 1'b0; i_last = 1'b0;
        checks++;
        if (bus0.o_valid !== 1'b1 || bus0.o_data !== 32'h00002211) begin
            errors++; $display("FAIL last_data got %b/%h exp 1/00002211", bus0.o_valid, bus0.o_data);
        end
        checks++;
        if (bus0.o_keep !== 4'b0011 || bus0.o_last !== 1'b1) begin
            errors++; $display("FAIL last_keep got %b/%b exp 0011/1", bus0.o_keep, bus0.o_last);
        end
        checks++;
        if (bus1.o_data !== 32'h11220000 || bus1.o_keep !== 4'b1100) begin
            errors++; $display("FAIL last_order1 got %h/%b exp 11220000/1100", bus1.o_data, bus1.o_keep);
        end
        for (int b = 1; b <= 4; b++) begin
            i_valid = 1'b1; i_data = 8'(b); i_last = (b == 4);
            @(negedge clk);
        end
        i_valid = 1'b0; i_last = 1'b0;
        checks++;
        if (bus0.o_data !== 32'h04030201 || bus0.o_keep !== 4'b1111 || bus0.o_last !== 1'b1) begin
            errors++; $display("FAIL last_full got %h/%b/%b exp 04030201/1111/1", bus0.o_data, bus0.o_keep, bus0.o_last);
        end
        for (int b = 5; b <= 8; b++) begin
            i_valid = 1'b1; i_data = 8'(b);
            @(negedge clk);
        end
        i_valid = 1'b0;
        checks++;
        if (bus0.o_data !== 32'h08070605 || bus0.o_keep !== 4'b1111 || bus0.o_last !== 1'b0) begin
            errors++; $display("FAIL last_plain got %h/%b/%b exp 08070605/1111/0", bus0.o_data, bus0.o_keep, bus0.o_last);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
`ifdef S_TO_P_LAST_EN
        i_last = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
`ifdef S_TO_P_LAST_EN
        test_last();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
